// File: rtl/wb_trace_buffer_pkg.sv
// Shared CPU constants: reset vector, register file size and the
// write-back trace entry layout used by the trace buffer.
package wb_trace_buffer_pkg;

  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;
  localparam int          GPR_NUM  = 32;

  localparam int TRACE_PC_W    = 32;
  localparam int TRACE_ADDR_W  = 5;
  localparam int TRACE_DATA_W  = 32;
  localparam int TRACE_ENTRY_W = TRACE_PC_W + 1 + TRACE_ADDR_W + TRACE_DATA_W;

  typedef struct packed {
    logic [TRACE_PC_W-1:0]   pc;
    logic                    wen;
    logic [TRACE_ADDR_W-1:0] addr;
    logic [TRACE_DATA_W-1:0] wdata;
  } trace_entry_t;

  function automatic trace_entry_t pack_entry(
    input logic [TRACE_PC_W-1:0]   pc,
    input logic                    wen,
    input logic [TRACE_ADDR_W-1:0] addr,
    input logic [TRACE_DATA_W-1:0] wdata
  );
    trace_entry_t e;
    e.pc    = pc;
    e.wen   = wen;
    e.addr  = addr;
    e.wdata = wdata;
    return e;
  endfunction

endpackage

// File: rtl/wb_trace_mem.sv
// Trace entry storage: DEPTH entries, two write ports, one asynchronous read.
// Contents are intentionally not reset; occupancy is tracked by the owner.
module wb_trace_mem
  import wb_trace_buffer_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         we0,
  input  logic [$clog2(DEPTH)-1:0]     waddr0,
  input  logic [TRACE_ENTRY_W-1:0]     wdata0,
  input  logic                         we1,
  input  logic [$clog2(DEPTH)-1:0]     waddr1,
  input  logic [TRACE_ENTRY_W-1:0]     wdata1,
  input  logic [$clog2(DEPTH)-1:0]     raddr,
  output logic [TRACE_ENTRY_W-1:0]     rdata
);

  logic [TRACE_ENTRY_W-1:0] mem_q [DEPTH];

  // The owner never drives both ports to the same address in one cycle.
  always_ff @(posedge clk) begin
    if (we0) mem_q[waddr0] <= wdata0;
    if (we1) mem_q[waddr1] <= wdata1;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/wb_trace_buffer.sv
// Captures CPU write-back commits (1 or 2 lanes per cycle) into a FIFO for
// a debug consumer, counting commits lost to a full buffer.
module wb_trace_buffer
  import wb_trace_buffer_pkg::*;
#(
  parameter int LANES      = 1,
  parameter int DEPTH      = 16,
  parameter int FILTER_WEN = 0,
  parameter int CNT_W      = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [LANES-1:0]          wb_valid,
  input  logic [32*LANES-1:0]       wb_pc,
  input  logic [LANES-1:0]          wb_rf_wen,
  input  logic [5*LANES-1:0]        wb_rf_addr,
  input  logic [32*LANES-1:0]       wb_rf_wdata,
  input  logic                      freeze,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [31:0]               out_pc,
  output logic                      out_rf_wen,
  output logic [4:0]                out_rf_addr,
  output logic [31:0]               out_rf_wdata,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      overflow,
  output logic [CNT_W-1:0]          drop_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int DW = CNT_W + 1;

  // Handshake: an entry leaves the buffer on a cycle where out_valid and
  // out_ready are both high; out_* stay stable while out_ready is low.

  trace_entry_t lane_entry [2];
  logic [1:0]   lane_qual;

  for (genvar i = 0; i < 2; i++) begin : g_lane
    if (i < LANES) begin : g_on
      assign lane_entry[i] = pack_entry(wb_pc[32*i +: 32], wb_rf_wen[i],
                                        wb_rf_addr[5*i +: 5], wb_rf_wdata[32*i +: 32]);
      assign lane_qual[i]  = wb_valid[i] & ~freeze &
                             ((FILTER_WEN == 0) | (wb_rf_wen[i] & (wb_rf_addr[5*i +: 5] != 5'd0)));
    end else begin : g_off
      assign lane_entry[i] = '0;
      assign lane_qual[i]  = 1'b0;
    end
  end

  logic [CW-1:0]    count_q, count_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic             overflow_q, overflow_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  logic             pop;
  logic [CW-1:0]    free;
  logic [1:0]       n_push;
  logic [1:0]       n_drop;
  logic [DW-1:0]    drop_sum;
  logic             we0, we1;
  trace_entry_t     wd0, wd1;
  logic [TRACE_ENTRY_W-1:0] rdata;
  trace_entry_t     head;

  assign out_valid = (count_q != '0);

  always_comb begin
    pop      = out_valid & out_ready;
    free     = CW'(DEPTH) - count_q + CW'(pop);
    we0      = 1'b0;
    we1      = 1'b0;
    wd0      = lane_entry[0];
    wd1      = lane_entry[1];
    n_push   = 2'd0;
    n_drop   = 2'd0;

    // Lane 0 claims the first free slot, so a younger lane can never be
    // kept while an older one is dropped.
    if (lane_qual[0]) begin
      if (free != '0) begin
        we0    = 1'b1;
        n_push = 2'd1;
      end else begin
        n_drop = 2'd1;
      end
    end

    if (lane_qual[1]) begin
      if (free > CW'(n_push)) begin
        if (n_push == 2'd0) begin
          we0 = 1'b1;
          wd0 = lane_entry[1];
        end else begin
          we1 = 1'b1;
        end
        n_push = n_push + 2'd1;
      end else begin
        n_drop = n_drop + 2'd1;
      end
    end

    count_d    = count_q + CW'(n_push) - CW'(pop);
    wr_ptr_d   = wr_ptr_q + PW'(n_push);
    rd_ptr_d   = rd_ptr_q + PW'(pop);
    drop_sum   = {1'b0, drop_cnt_q} + DW'(n_drop);
    drop_cnt_d = drop_sum[CNT_W] ? {CNT_W{1'b1}} : drop_sum[CNT_W-1:0];
    overflow_d = overflow_q | (n_drop != 2'd0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  wb_trace_mem #(
    .DEPTH (DEPTH)
  ) u_mem (
    .clk    (clk),
    .we0    (we0),
    .waddr0 (wr_ptr_q),
    .wdata0 (wd0),
    .we1    (we1),
    .waddr1 (wr_ptr_q + PW'(1)),
    .wdata1 (wd1),
    .raddr  (rd_ptr_q),
    .rdata  (rdata)
  );

  assign head         = trace_entry_t'(rdata);
  assign out_pc       = head.pc;
  assign out_rf_wen   = head.wen;
  assign out_rf_addr  = head.addr;
  assign out_rf_wdata = head.wdata;
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign drop_cnt     = drop_cnt_q;

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Directed bench for wb_trace_buffer: a 2-lane DEPTH=4 CNT_W=2 instance and a
// 1-lane DEPTH=4 filtered instance share one clock and reset.
module tb_wb_trace_buffer;
  import wb_trace_buffer_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- 2-lane instance ----------------
  logic [1:0]  a_valid = '0;
  logic [63:0] a_pc = '0;
  logic [1:0]  a_wen = '0;
  logic [9:0]  a_addr = '0;
  logic [63:0] a_wdata = '0;
  logic        a_freeze = 1'b0;
  logic        a_ready = 1'b0;
  logic        a_out_valid, a_out_wen, a_overflow;
  logic [31:0] a_out_pc, a_out_wdata;
  logic [4:0]  a_out_addr;
  logic [2:0]  a_count;
  logic [1:0]  a_drop;

  wb_trace_buffer #(.LANES(2), .DEPTH(4), .FILTER_WEN(0), .CNT_W(2)) dut_a (
    .clk(clk), .rst(rst),
    .wb_valid(a_valid), .wb_pc(a_pc), .wb_rf_wen(a_wen),
    .wb_rf_addr(a_addr), .wb_rf_wdata(a_wdata), .freeze(a_freeze),
    .out_valid(a_out_valid), .out_ready(a_ready),
    .out_pc(a_out_pc), .out_rf_wen(a_out_wen), .out_rf_addr(a_out_addr),
    .out_rf_wdata(a_out_wdata), .count(a_count), .overflow(a_overflow),
    .drop_cnt(a_drop)
  );

  // ---------------- 1-lane filtered instance ----------------
  logic        f_valid = 1'b0;
  logic [31:0] f_pc = '0;
  logic        f_wen = 1'b0;
  logic [4:0]  f_addr = '0;
  logic [31:0] f_wdata = '0;
  logic        f_freeze = 1'b0;
  logic        f_ready = 1'b0;
  logic        f_out_valid, f_out_wen, f_overflow;
  logic [31:0] f_out_pc, f_out_wdata;
  logic [4:0]  f_out_addr;
  logic [2:0]  f_count;
  logic [15:0] f_drop;

  wb_trace_buffer #(.LANES(1), .DEPTH(4), .FILTER_WEN(1), .CNT_W(16)) dut_f (
    .clk(clk), .rst(rst),
    .wb_valid(f_valid), .wb_pc(f_pc), .wb_rf_wen(f_wen),
    .wb_rf_addr(f_addr), .wb_rf_wdata(f_wdata), .freeze(f_freeze),
    .out_valid(f_out_valid), .out_ready(f_ready),
    .out_pc(f_out_pc), .out_rf_wen(f_out_wen), .out_rf_addr(f_out_addr),
    .out_rf_wdata(f_out_wdata), .count(f_count), .overflow(f_overflow),
    .drop_cnt(f_drop)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_head_a(input string tag);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_empty_q"}, 64'd1, 64'd0);
    end else begin
      e = exp_q.pop_front();
      check(tag, {32'd0, a_out_pc}, {32'd0, e});
    end
  endtask

  // ---------------- drivers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic a_drive(input logic [1:0] v, input logic [31:0] pc0, input logic [31:0] pc1);
    a_valid = v;
    a_pc    = {pc1, pc0};
    a_wen   = 2'b11;
    a_addr  = {5'd2, 5'd1};
    a_wdata = {pc1 ^ 32'hFFFF_FFFF, pc0 ^ 32'hFFFF_FFFF};
  endtask

  task automatic f_drive(input logic v, input logic [31:0] pc, input logic wen,
                         input logic [4:0] addr, input logic [31:0] wdata);
    f_valid = v;
    f_pc    = pc;
    f_wen   = wen;
    f_addr  = addr;
    f_wdata = wdata;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    step();
    step();
    check("rst_a_out_valid", {63'd0, a_out_valid}, 64'd0);
    check("rst_a_count",     {61'd0, a_count},     64'd0);
    check("rst_a_overflow",  {63'd0, a_overflow},  64'd0);
    check("rst_a_drop",      {62'd0, a_drop},      64'd0);
    check("rst_f_count",     {61'd0, f_count},     64'd0);
    rst = 1'b0;

    // In-order capture and one-cycle latency on the 1-lane instance.
    f_drive(1'b1, RESET_PC, 1'b1, 5'd1, 32'h11);
    step();
    check("lat_f_out_valid", {63'd0, f_out_valid}, 64'd1);
    check("lat_f_count",     {61'd0, f_count},     64'd1);
    f_drive(1'b1, RESET_PC + 32'd4, 1'b1, 5'd1, 32'h22);
    step();
    f_drive(1'b1, RESET_PC + 32'd8, 1'b1, 5'd1, 32'h33);
    step();
    f_drive(1'b0, 32'd0, 1'b0, 5'd0, 32'd0);
    check("seq_f_count3", {61'd0, f_count}, 64'd3);
    step();
    check("hold_f_pc", {32'd0, f_out_pc}, {32'd0, RESET_PC});
    check("hold_f_count", {61'd0, f_count}, 64'd3);
    exp_q.push_back(RESET_PC);
    exp_q.push_back(RESET_PC + 32'd4);
    exp_q.push_back(RESET_PC + 32'd8);
    f_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      logic [31:0] e;
      e = exp_q.pop_front();
      check($sformatf("order_f_pc%0d", i), {32'd0, f_out_pc}, {32'd0, e});
      step();
    end
    f_ready = 1'b0;
    check("drain_f_count", {61'd0, f_count}, 64'd0);
    check("drain_f_valid", {63'd0, f_out_valid}, 64'd0);

    // Filter: only a write to a non-zero register is captured.
    f_drive(1'b1, 32'h500, 1'b0, 5'd3, 32'h1111_1111);
    step();
    f_drive(1'b1, 32'h504, 1'b1, 5'd0, 32'h2222_2222);
    step();
    f_drive(1'b1, 32'h508, 1'b1, 5'd8, 32'hDEAD_BEEF);
    step();
    f_drive(1'b0, 32'd0, 1'b0, 5'd0, 32'd0);
    check("filt_f_count", {61'd0, f_count}, 64'd1);
    check("filt_f_wdata", {32'd0, f_out_wdata}, {32'd0, 32'hDEAD_BEEF});
    check("filt_f_addr",  {59'd0, f_out_addr}, 64'd8);
    check("filt_f_pc",    {32'd0, f_out_pc}, 64'h508);
    check("filt_f_drop",  {48'd0, f_drop}, 64'd0);
    f_ready = 1'b1;
    step();
    f_ready = 1'b0;
    check("filt_f_empty", {61'd0, f_count}, 64'd0);

    // Two-lane fill up to count=3, then overflow on lane 1.
    a_drive(2'b11, 32'h10, 32'h14);
    step();
    check("fill_a_count2", {61'd0, a_count}, 64'd2);
    a_drive(2'b01, 32'h18, 32'h0);
    step();
    check("fill_a_count3", {61'd0, a_count}, 64'd3);
    a_drive(2'b11, 32'h100, 32'h104);
    step();
    check("ovf_a_count",    {61'd0, a_count},    64'd4);
    check("ovf_a_drop",     {62'd0, a_drop},     64'd1);
    check("ovf_a_overflow", {63'd0, a_overflow}, 64'd1);

    // Full buffer: a pop frees one slot for lane 0; lane 1 is dropped.
    check("full_a_head", {32'd0, a_out_pc}, 64'h10);
    a_ready = 1'b1;
    a_drive(2'b11, 32'h200, 32'h204);
    step();
    a_drive(2'b00, 32'h0, 32'h0);
    check("popfull_a_count", {61'd0, a_count}, 64'd4);
    check("popfull_a_drop",  {62'd0, a_drop},  64'd2);
    exp_q.push_back(32'h14);
    exp_q.push_back(32'h18);
    exp_q.push_back(32'h100);
    exp_q.push_back(32'h200);
    for (int i = 0; i < 4; i++) begin
      check_head_a($sformatf("drain_a_pc%0d", i));
      step();
    end
    a_ready = 1'b0;
    check("drain_a_count", {61'd0, a_count}, 64'd0);
    check("drain_a_valid", {63'd0, a_out_valid}, 64'd0);

    // Freeze while full, then saturate the 2-bit drop counter with 5 drops.
    pulse_reset();
    check("rst2_a_overflow", {63'd0, a_overflow}, 64'd0);
    check("rst2_a_drop",     {62'd0, a_drop},     64'd0);
    a_drive(2'b11, 32'h400, 32'h404);
    step();
    a_drive(2'b11, 32'h408, 32'h40C);
    step();
    check("fill2_a_count", {61'd0, a_count}, 64'd4);
    a_freeze = 1'b1;
    a_drive(2'b11, 32'h410, 32'h414);
    step();
    check("frz_a_count",    {61'd0, a_count},    64'd4);
    check("frz_a_drop",     {62'd0, a_drop},     64'd0);
    check("frz_a_overflow", {63'd0, a_overflow}, 64'd0);
    a_freeze = 1'b0;
    step();
    check("drop2_a_drop", {62'd0, a_drop}, 64'd2);
    a_drive(2'b01, 32'h418, 32'h0);
    step();
    check("drop3_a_drop", {62'd0, a_drop}, 64'd3);
    a_drive(2'b11, 32'h41C, 32'h420);
    step();
    a_drive(2'b00, 32'h0, 32'h0);
    check("sat_a_drop",  {62'd0, a_drop},  64'd3);
    check("sat_a_count", {61'd0, a_count}, 64'd4);
    check("sat_a_head",  {32'd0, a_out_pc}, 64'h400);

    // Asynchronous reset mid-burst with two entries left.
    a_ready = 1'b1;
    step();
    step();
    a_ready = 1'b0;
    check("pre_rst_a_count", {61'd0, a_count}, 64'd2);
    a_drive(2'b11, 32'h300, 32'h304);
    #3;
    rst = 1'b1;
    #1;
    check("arst_a_valid",    {63'd0, a_out_valid}, 64'd0);
    check("arst_a_count",    {61'd0, a_count},     64'd0);
    check("arst_a_overflow", {63'd0, a_overflow},  64'd0);
    check("arst_a_drop",     {62'd0, a_drop},      64'd0);
    step();
    check("inrst_a_count", {61'd0, a_count}, 64'd0);
    rst = 1'b0;
    step();
    a_drive(2'b00, 32'h0, 32'h0);
    check("resume_a_count", {61'd0, a_count}, 64'd2);
    check("resume_a_head",  {32'd0, a_out_pc}, 64'h300);
    check("resume_a_drop",  {62'd0, a_drop}, 64'd0);
    a_ready = 1'b1;
    step();
    a_ready = 1'b0;
    check("resume_a_head2", {32'd0, a_out_pc}, 64'h304);
    check("resume_a_count1", {61'd0, a_count}, 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/wb_trace_buffer.md
WB_TRACE_BUFFER -- requirements
Module: wb_trace_buffer

Interface
REQ-001 Parameter LANES, default 1, number of commit lanes sampled per cycle; legal values 1 or 2.
REQ-002 Parameter DEPTH, default 16, number of buffer entries; power of two, 4..256.
REQ-003 Parameter FILTER_WEN, default 0; when 1, only register-file writes to a non-zero register are captured.
REQ-004 Parameter CNT_W, default 16, width of the drop counter.
REQ-005 clk  in  1  single clock; all state updates on its rising edge.
REQ-006 rst  in  1  reset, asynchronous and active-high.
REQ-007 wb_valid  in  LANES  per-lane commit strobe; lane 0 is the older commit.
REQ-008 wb_pc  in  32*LANES  per-lane debug_wb_pc; lane i at bits [32i+31:32i].
REQ-009 wb_rf_wen  in  LANES  per-lane debug_wb_rf_wen.
REQ-010 wb_rf_addr  in  5*LANES  per-lane debug_wb_rf_addr.
REQ-011 wb_rf_wdata  in  32*LANES  per-lane debug_wb_rf_wdata.
REQ-012 freeze  in  1  when high, no lane is captured and the drop counter is unchanged.
REQ-013 out_valid  out  1  the oldest entry is presented.
REQ-014 out_ready  in  1  the consumer accepts the presented entry.
REQ-015 out_pc, out_rf_wen, out_rf_addr, out_rf_wdata  out  32/1/5/32  fields of the oldest entry.
REQ-016 count  out  $clog2(DEPTH)+1  number of occupied entries.
REQ-017 overflow  out  1  sticky flag; set when any qualified commit is dropped.
REQ-018 drop_cnt  out  CNT_W  saturating count of dropped qualified commits.

Function
REQ-019 A lane is qualified when wb_valid[i]=1, freeze=0, and, if FILTER_WEN=1, wb_rf_wen[i]=1 and wb_rf_addr[i]!=0.
REQ-020 A pop occurs when out_valid=1 and out_ready=1.
REQ-021 Free space in a cycle = DEPTH - count + pop; a pop in the same cycle frees its slot for that cycle's pushes.
REQ-022 Qualified lanes are written in lane order (lane 0 first) into consecutive slots, up to the free space.
REQ-023 When free space is less than the number of qualified lanes, the lowest-numbered lanes are stored and the remainder dropped; no older commit is dropped while a younger one is kept.
REQ-024 Each dropped qualified lane increments drop_cnt by 1; a cycle with 2 drops adds 2; drop_cnt saturates at 2^CNT_W-1.
REQ-025 overflow is set in the cycle after the first drop and stays set until reset.
REQ-026 Unqualified lanes (filtered or frozen) are not counted as drops.
REQ-027 Capture latency is 1 cycle: a commit stored at edge N is visible on out_* after edge N when the buffer was empty; there is no combinational bypass.
REQ-028 out_* hold the head entry stable while out_valid=1 and out_ready=0.
REQ-029 out_valid = (count != 0); out_* data is don't-care when out_valid=0.
REQ-030 The read and write pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH; a full buffer is distinguished from an empty one by count.
REQ-031 count updates as count + pushes - pop each cycle and never exceeds DEPTH.

Reset
REQ-032 Asserting rst immediately clears count, both pointers, overflow and drop_cnt, and forces out_valid=0; storage contents are not reset.
REQ-033 Commits presented while rst=1 are ignored and not counted as drops.
REQ-034 Asserting rst during a pop or push discards all entries; the first capture happens at the first rising edge after rst deasserts.

Structure
REQ-035 The trace-entry field widths (PC 32, register address 5, data 32, packed entry 70) are constants in the shared cpu package, alongside the existing pipeline constants.
REQ-036 Entry storage is one sub-module, wb_trace_mem: DEPTH x 70 bits, 2 write ports, 1 asynchronous read port.
REQ-037 Pointer, count, drop and filter logic reside in wb_trace_buffer.

Verification
REQ-038 LANES=1, DEPTH=4: commit pc 0xBFC00000/0xBFC00004/0xBFC00008 on consecutive cycles with out_ready=0 -> count=3; then raise out_ready -> same three PCs are presented in order.
REQ-039 LANES=2, DEPTH=4, count=3, no pop, both lanes valid (pc 0x100 lane0, 0x104 lane1) -> 0x100 stored, count=4, drop_cnt=1, overflow=1.
REQ-040 Full buffer, pop and two qualified lanes in the same cycle -> lane0 stored, lane1 dropped, count stays 4, drop_cnt +1.
REQ-041 FILTER_WEN=1: commits (wen=0, addr=3) and (wen=1, addr=0) and (wen=1, addr=8, wdata=0xDEADBEEF) -> only the third is captured, drop_cnt=0.
REQ-042 CNT_W=2: force 5 drops -> drop_cnt saturates at 3; freeze=1 with valid commits -> count and drop_cnt unchanged.
REQ-043 Assert rst asynchronously mid-burst with count=2 -> out_valid=0, count=0, overflow=0 before the next clk edge; normal capture resumes after rst deasserts.
